// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_pkg
// Brief    : Shared types for shift_seq_ctrl: shift-register commands, FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package shift_pkg;

  typedef enum logic [1:0] {
    NA    = 2'b00,
    LOAD  = 2'b01,
    LEFT  = 2'b10,
    RIGHT = 2'b11
  } funct_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_seq_ctrl
// Brief    : Sequences LOAD then WIDTH shifts of an external shift register,
//            serialising word_i on tx_o and collecting rx_i into result_o.
//            Optional macro SHIFT_SEQ_ABORT_EN adds the abort_i port.
// Revision : 1.0 - initial release
// ============================================================================
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid_i,
  output logic             start_ready_o,
  input  logic [WIDTH-1:0] word_i,
  input  logic             dir_i,
  input  logic             rx_i,
  output logic             tx_o,
  output funct_t           sr_funct_o,
  output logic [WIDTH-1:0] sr_word_o,
  output logic             sr_serial_o,
  input  logic [WIDTH-1:0] sr_q_i,
`ifdef SHIFT_SEQ_ABORT_EN
  input  logic             abort_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dir;
  logic [WIDTH-1:0] r_result;

  logic             w_accept;
  logic             w_abort;
  logic             w_last;
  logic [WIDTH-1:0] w_next_q;

`ifdef SHIFT_SEQ_ABORT_EN
  assign w_abort = abort_i && (r_state == SHIFT);
`else
  assign w_abort = 1'b0;
`endif

  assign w_accept = start_valid_i && (r_state == IDLE);
  assign w_last   = (r_cnt == CNT_W'(1));
  // Value the external register will hold after the current shift edge.
  assign w_next_q = r_dir ? {rx_i, sr_q_i[WIDTH-1:1]} : {sr_q_i[WIDTH-2:0], rx_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_dir    <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_dir   <= dir_i;
            r_cnt   <= CNT_W'(WIDTH);
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_abort) begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (w_last) begin
              r_result <= w_next_q;
              r_state  <= DONE;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    start_ready_o = 1'b0;
    busy_o        = 1'b0;
    done_o        = 1'b0;
    tx_o          = 1'b0;
    sr_funct_o    = NA;
    sr_word_o     = '0;
    sr_serial_o   = 1'b0;
    case (r_state)
      IDLE: begin
        start_ready_o = 1'b1;
        if (w_accept) begin
          sr_funct_o = LOAD;
          sr_word_o  = word_i;
        end
      end
      SHIFT: begin
        busy_o      = 1'b1;
        sr_serial_o = rx_i;
        tx_o        = r_dir ? sr_q_i[0] : sr_q_i[WIDTH-1];
        if (!w_abort) begin
          sr_funct_o = r_dir ? RIGHT : LEFT;
        end
      end
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

  assign result_o = r_result;

endmodule
`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_seq_ctrl
// Brief    : Self-checking bench for shift_seq_ctrl with an external shift register.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_seq_ctrl;
  import shift_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_valid_i = 1'b0;
  logic         dir_i = 1'b0;
  logic         rx_i = 1'b0;
  logic [W-1:0] word_i = '0;
  logic [W-1:0] sr_word_o;
  logic [W-1:0] sr_q;
  logic [W-1:0] result_o;
  logic         start_ready_o, tx_o, sr_serial_o, busy_o, done_o;
  funct_t       sr_funct_o;
`ifdef SHIFT_SEQ_ABORT_EN
  logic         abort_i = 1'b0;
`endif

  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] model_result = '0;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid_i(start_valid_i),
    .start_ready_o(start_ready_o),
    .word_i       (word_i),
    .dir_i        (dir_i),
    .rx_i         (rx_i),
    .tx_o         (tx_o),
    .sr_funct_o   (sr_funct_o),
    .sr_word_o    (sr_word_o),
    .sr_serial_o  (sr_serial_o),
    .sr_q_i       (sr_q),
`ifdef SHIFT_SEQ_ABORT_EN
    .abort_i      (abort_i),
`endif
    .busy_o       (busy_o),
    .done_o       (done_o),
    .result_o     (result_o)
  );

  // The shift register the parent places next to the controller.
  always_ff @(posedge clk) begin
    if (rst) sr_q <= '0;
    else begin
      case (sr_funct_o)
        LOAD:    sr_q <= sr_word_o;
        LEFT:    sr_q <= {sr_q[W-2:0], sr_serial_o};
        RIGHT:   sr_q <= {sr_serial_o, sr_q[W-1:1]};
        default: sr_q <= sr_q;
      endcase
    end
  end

  // rx bit k (k-th one sent) ends at MSB-k when shifting left, at bit k when shifting right.
  function automatic logic [W-1:0] exp_result(input logic dir, input logic [W-1:0] rx_vec);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < W; k++) begin
      if (dir) r[k] = rx_vec[k];
      else     r[W-1-k] = rx_vec[k];
    end
    return r;
  endfunction

  task automatic do_transfer(input logic [W-1:0] word, input logic dir,
                             input logic [W-1:0] rx_vec, input bit noisy);
    logic   exp_tx;
    funct_t exp_f;
    exp_f = dir ? RIGHT : LEFT;
    @(negedge clk);
    start_valid_i = 1'b1; word_i = word; dir_i = dir; rx_i = 1'($urandom);
    #1;
    n_cmp++;
    if (start_ready_o !== 1'b1 || sr_funct_o !== LOAD || sr_word_o !== word || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL accept: ready=%b funct=%0d word=%h busy=%b, want 1 %0d %h 0",
               start_ready_o, sr_funct_o, sr_word_o, busy_o, LOAD, word);
    end
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      start_valid_i = noisy ? 1'($urandom) : 1'b0;
      word_i = W'($urandom); dir_i = 1'($urandom); rx_i = rx_vec[k];
      #1;
      exp_tx = dir ? word[k] : word[W-1-k];
      n_cmp++;
      if (busy_o !== 1'b1 || start_ready_o !== 1'b0 || done_o !== 1'b0 || sr_funct_o !== exp_f ||
          sr_serial_o !== rx_vec[k] || sr_word_o !== '0 || result_o !== model_result) begin
        n_err++;
        $display("FAIL shift%0d: busy=%b ready=%b done=%b funct=%0d ser=%b sw=%h res=%h, want 1 0 0 %0d %b 0 %h",
                 k, busy_o, start_ready_o, done_o, sr_funct_o, sr_serial_o, sr_word_o, result_o,
                 exp_f, rx_vec[k], model_result);
      end
      n_cmp++;
      if (tx_o !== exp_tx) begin
        n_err++;
        $display("FAIL tx%0d: got %b want %b", k, tx_o, exp_tx);
      end
    end
    @(negedge clk);
    start_valid_i = noisy ? 1'($urandom) : 1'b0;
    #1;
    model_result = exp_result(dir, rx_vec);
    n_cmp++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || start_ready_o !== 1'b0 || sr_funct_o !== NA ||
        tx_o !== 1'b0 || result_o !== model_result) begin
      n_err++;
      $display("FAIL done: done=%b busy=%b ready=%b funct=%0d tx=%b res=%h, want 1 0 0 0 0 %h",
               done_o, busy_o, start_ready_o, sr_funct_o, tx_o, result_o, model_result);
    end
    @(negedge clk);
    start_valid_i = 1'b0;
    #1;
    n_cmp++;
    if (done_o !== 1'b0 || start_ready_o !== 1'b1 || sr_funct_o !== NA || result_o !== model_result) begin
      n_err++;
      $display("FAIL post_idle: done=%b ready=%b funct=%0d res=%h, want 0 1 0 %h",
               done_o, start_ready_o, sr_funct_o, result_o, model_result);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (start_ready_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== '0 || sr_funct_o !== NA) begin
      n_err++;
      $display("FAIL reset: ready=%b busy=%b done=%b res=%h funct=%0d, want 1 0 0 0 0",
               start_ready_o, busy_o, done_o, result_o, sr_funct_o);
    end
    rst = 1'b0;
    model_result = '0;
  endtask

  task automatic test_left();
    do_transfer(4'b1011, 1'b0, 4'b0110, 1'b0);
    n_cmp++;
    if (result_o !== 4'b0110) begin
      n_err++;
      $display("FAIL left_result: got %b want 0110", result_o);
    end
  endtask

  task automatic test_right();
    do_transfer(4'b1011, 1'b1, 4'b1001, 1'b0);
    n_cmp++;
    if (result_o !== 4'b1001) begin
      n_err++;
      $display("FAIL right_result: got %b want 1001", result_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] rx1, rx2, w1, w2;
    logic         d1, d2;
    rx1 = W'($urandom); rx2 = W'($urandom); w1 = W'($urandom); w2 = W'($urandom);
    d1 = 1'($urandom); d2 = 1'($urandom);
    @(negedge clk);
    start_valid_i = 1'b1; word_i = w1; dir_i = d1;
    for (int c = 0; c <= W + 2; c++) begin
      if (c > 0) @(negedge clk);
      if (c >= 1 && c <= W) rx_i = rx1[c-1];
      if (c == W + 2) begin word_i = w2; dir_i = d2; end
      #1;
      if (c == W + 1) model_result = exp_result(d1, rx1);
      n_cmp++;
      if (start_ready_o !== (c == 0 || c == W + 2) || done_o !== (c == W + 1) ||
          (sr_funct_o == LOAD) !== (c == 0 || c == W + 2) || result_o !== model_result) begin
        n_err++;
        $display("FAIL b2b_c%0d: ready=%b done=%b funct=%0d res=%h, want ready=%b done=%b res=%h",
                 c, start_ready_o, done_o, sr_funct_o, result_o,
                 (c == 0 || c == W + 2), (c == W + 1), model_result);
      end
    end
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      start_valid_i = 1'b0; rx_i = rx2[k];
    end
    @(negedge clk);
    #1;
    model_result = exp_result(d2, rx2);
    n_cmp++;
    if (done_o !== 1'b1 || result_o !== model_result) begin
      n_err++;
      $display("FAIL b2b_second: done=%b res=%h, want 1 %h", done_o, result_o, model_result);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start_valid_i = 1'b1; word_i = 4'b1100; dir_i = 1'b0;
    repeat (2) begin
      @(negedge clk);
      start_valid_i = 1'b0; rx_i = 1'($urandom);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    model_result = '0;
    n_cmp++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || start_ready_o !== 1'b1 || result_o !== '0 || sr_funct_o !== NA) begin
      n_err++;
      $display("FAIL reset_mid: busy=%b done=%b ready=%b res=%h funct=%0d, want 0 0 1 0 0",
               busy_o, done_o, start_ready_o, result_o, sr_funct_o);
    end
    rst = 1'b0;
    for (int c = 0; c < W + 2; c++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
        n_err++;
        $display("FAIL reset_mid_quiet%0d: done=%b busy=%b, want 0 0", c, done_o, busy_o);
      end
    end
    do_transfer(W'($urandom), 1'($urandom), W'($urandom), 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      do_transfer(W'($urandom), 1'($urandom), W'($urandom), 1'b1);
    end
  endtask

`ifdef SHIFT_SEQ_ABORT_EN
  task automatic test_abort();
    int pos [2];
    pos[0] = 1; pos[1] = W - 1;
    do_transfer(W'($urandom), 1'($urandom), W'($urandom), 1'b0);
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      start_valid_i = 1'b1; word_i = W'($urandom); dir_i = 1'($urandom);
      for (int s = 0; s <= pos[p]; s++) begin
        @(negedge clk);
        start_valid_i = 1'b0; rx_i = 1'($urandom);
        abort_i = (s == pos[p]);
      end
      #1;
      n_cmp++;
      if (sr_funct_o !== NA) begin
        n_err++;
        $display("FAIL abort_funct%0d: got %0d want 0", p, sr_funct_o);
      end
      @(negedge clk);
      abort_i = 1'b0;
      #1;
      n_cmp++;
      if (busy_o !== 1'b0 || done_o !== 1'b0 || start_ready_o !== 1'b1 || result_o !== model_result) begin
        n_err++;
        $display("FAIL abort_idle%0d: busy=%b done=%b ready=%b res=%h, want 0 0 1 %h",
                 p, busy_o, done_o, start_ready_o, result_o, model_result);
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if (done_o !== 1'b0) begin
        n_err++;
        $display("FAIL abort_nodone%0d: done=%b want 0", p, done_o);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_left();
    test_right();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef SHIFT_SEQ_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, register width in bits; WIDTH SHALL be >= 2.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start_valid_i  input  1  request to start a frame transfer.
REQ-005 start_ready_o  output  1  controller can accept a request.
REQ-006 word_i  input  WIDTH  transmit word; sampled on accept.
REQ-007 dir_i  input  1  direction: 0 = MSB first (LEFT), 1 = LSB first (RIGHT); sampled on accept.
REQ-008 rx_i  input  1  serial receive bit.
REQ-009 tx_o  output  1  serial transmit bit.
REQ-010 sr_funct_o  output  funct_t (2)  command to the external shift register.
REQ-011 sr_word_o  output  WIDTH  parallel load word to the shift register.
REQ-012 sr_serial_o  output  1  serial-in bit to the shift register.
REQ-013 sr_q_i  input  WIDTH  current shift register contents.
REQ-014 busy_o  output  1  transfer in progress.
REQ-015 done_o  output  1  one-cycle completion pulse.
REQ-016 result_o  output  WIDTH  last completed received word.

Function
REQ-017 The FSM SHALL have states IDLE, SHIFT, and DONE.
REQ-018 IDLE behaviour:
- start_ready_o=1, busy_o=0, sr_funct_o=NA.
- On accept (start_valid_i & start_ready_o), in the same cycle: sr_funct_o=LOAD and sr_word_o=word_i.
- dir_i is latched, the bit counter is set to WIDTH, and the FSM moves to SHIFT.
REQ-019 SHIFT behaviour:
- start_ready_o=0, busy_o=1.
- sr_funct_o = LEFT if the latched dir is 0, otherwise RIGHT.
- sr_serial_o=rx_i (combinational).
- The counter decrements each cycle.
REQ-020 In SHIFT, tx_o SHALL be sr_q_i[WIDTH-1] for LEFT and sr_q_i[0] for RIGHT; in all other states tx_o=0.
REQ-021 SHIFT SHALL last exactly WIDTH cycles; on the edge ending the cycle where the counter equals 1, the FSM moves to DONE.
REQ-022 On that same edge, result_o SHALL load the shift register's next value:
- LEFT: {sr_q_i[WIDTH-2:0], rx_i}.
- RIGHT: {rx_i, sr_q_i[WIDTH-1:1]}.
REQ-023 DONE behaviour:
- Lasts one cycle, then the FSM returns to IDLE.
- done_o=1, busy_o=0, start_ready_o=0, sr_funct_o=NA.
REQ-024 Latency: with accept at cycle t, shifts occur at t+1..t+WIDTH, done_o is high at t+WIDTH+1, and the next accept is possible at t+WIDTH+2.
REQ-025 result_o SHALL hold its value until the next completion; sr_word_o SHALL be 0 whenever sr_funct_o != LOAD.
REQ-026 start_valid_i asserted outside IDLE SHALL be ignored; no requests are queued.

Reset
REQ-027 While rst=1, all of the following SHALL hold on the next edge:
- state=IDLE, counter=0, result_o=0, done_o=0, busy_o=0, start_ready_o=1, sr_funct_o=NA.
REQ-028 Reset mid-SHIFT SHALL abandon the transfer with no done_o pulse and result_o cleared.

Configuration
REQ-029 Macro SHIFT_SEQ_ABORT_EN, when defined:
- Adds the input port abort_i (1 bit).
- abort_i=1 in SHIFT forces sr_funct_o=NA in that cycle and IDLE on the next edge, with no done_o and result_o unchanged.
- Abort wins over last-shift completion.
- abort_i is ignored in IDLE and DONE.
REQ-030 When SHIFT_SEQ_ABORT_EN is undefined, the port SHALL be absent and every started transfer SHALL run to completion.

Structure
REQ-031 funct_t (NA=00, LOAD=01, LEFT=10, RIGHT=11) and the state enum SHALL live in shared package shift_pkg; the module SHALL import it.
REQ-032 No sub-module: the counter and FSM are inline; the shift register is instantiated by the parent alongside this block.

Verification (WIDTH=4, external shift register connected)
REQ-033 Reset: rst high 2 cycles -> start_ready_o=1, busy_o=0, done_o=0, result_o=0000, sr_funct_o=NA.
REQ-034 LEFT: word_i=1011, dir_i=0, rx_i=0,1,1,0 -> one LOAD cycle, then 4 LEFT cycles, tx_o=1,0,1,1, done_o at t+5, result_o=0110.
REQ-035 RIGHT: word_i=1011, dir_i=1, rx_i=1,0,0,1 -> tx_o=1,1,0,1, done_o at t+5, result_o=1001.
REQ-036 start_valid_i held high continuously -> accepts at t and t+6 only; start_ready_o low t+1..t+5.
REQ-037 Abort (macro defined): abort_i pulsed at the 2nd SHIFT cycle -> sr_funct_o=NA in that cycle, IDLE next cycle, no done_o, result_o keeps its prior value.
REQ-038 rst asserted during the 3rd SHIFT cycle -> IDLE next edge, no done_o, result_o=0000, then a new transfer completes normally.
